// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and baud divisor helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   // Rounded to the nearest whole input_clk cycle; the receiver uses the same divisor.
   function automatic int unsigned baud_div(input int unsigned clk_khz, input int unsigned baud);
      return (clk_khz * 32'd1000 + baud / 32'd2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - one-cycle tick every DIV input_clk cycles, restarted by clear.
module uart_baud_tick #(
   parameter int unsigned DIV = 10
) (
   input  logic input_clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick = (cnt_q == LAST);
      if (clear || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer: start, 8 data LSB first, optional parity, stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned INPUT_CLK_KHZ = 100_000,
   parameter int unsigned BAUD_RATE     = 9600,
   parameter int unsigned STOP_BITS     = 1,
   parameter int unsigned PARITY_ODD    = 0
) (
   input  logic       input_clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned BAUD_DIV  = baud_div(INPUT_CLK_KHZ, BAUD_RATE);
   localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
   end
   if (PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
   end

   uart_tx_state_t state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       stop_cnt_q, stop_cnt_d;
   logic       tx_q, tx_d;
   logic       ready_q, ready_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       tick;
   logic       clear;
   logic       accept;
`ifdef UART_TX_PARITY_EN
   logic       parity_q, parity_d;
`endif

   assign accept = tx_valid & ready_q;
   // Holding the divider in reset while idle makes the start bit exactly BAUD_DIV cycles long.
   assign clear  = (state_q == IDLE);

   uart_baud_tick #(
      .DIV(BAUD_DIV)
   ) u_baud_tick (
      .input_clk(input_clk),
      .reset    (reset),
      .clear    (clear),
      .tick     (tick)
   );

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = START;
               shreg_d    = tx_data;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_d   = ^tx_data ^ 1'(PARITY_ODD);
`endif
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  shreg_d   = {1'b0, shreg_q[7:1]};
               end
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) begin
               if (stop_cnt_q == LAST_STOP) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_cnt_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so every output is a flop.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge input_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer (8N1 and 8N2 instances).
module tb_uart_tx_serializer;

   localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_data = 8'h00, b_data = 8'h00;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       a_ready, a_tx, a_busy, a_done;
   logic       b_ready, b_tx, b_busy, b_done;

   int vectors = 0;
   int miscompares = 0;
   logic [8:0] mon_q[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(
      .INPUT_CLK_KHZ(1000), .BAUD_RATE(100_000), .STOP_BITS(1), .PARITY_ODD(0)
   ) dut_a (
      .input_clk(clk), .reset(rst), .tx_data(a_data), .tx_valid(a_valid),
      .tx_ready(a_ready), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done)
   );

   uart_tx_serializer #(
      .INPUT_CLK_KHZ(1000), .BAUD_RATE(100_000), .STOP_BITS(2), .PARITY_ODD(1)
   ) dut_b (
      .input_clk(clk), .reset(rst), .tx_data(b_data), .tx_valid(b_valid),
      .tx_ready(b_ready), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference frame: bit i of the result is the line level during bit period i.
   function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic odd);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (PAR == 1) f[9] = ^d ^ odd;
      return f;
   endfunction

   // Line monitor on instance A: samples mid-bit, drops frames cut by reset.
   always begin
      @(negedge clk);
      if (!rst && a_tx === 1'b0) begin : mon_frame
         logic [7:0] b;
         bit ok;
         bit abort;
         ok = 1'b1;
         abort = rst;
         b = '0;
         repeat (DIV / 2) @(negedge clk);
         abort |= rst;
         ok &= (a_tx === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            abort |= rst;
            b[i] = a_tx;
         end
         if (PAR == 1) begin
            repeat (DIV) @(negedge clk);
            abort |= rst;
         end
         repeat (DIV) @(negedge clk);
         abort |= rst;
         ok &= (a_tx === 1'b1);
         if (!abort) mon_q.push_back(ok ? {1'b0, b} : 9'h100);
         while (rst) @(negedge clk);
      end
   end

   task automatic send_check(input logic [7:0] d, input bit sel, input int exp_done,
                             input int poke_at, input logic exp_par, input string tag);
      int          stop;
      int          nb;
      int          waited;
      int          done_at;
      bit          wave_ok;
      logic [11:0] f;
      logic [7:0]  dec;
      logic        par_s, t, bz, rd, dn;
      stop    = sel ? 2 : 1;
      nb      = 9 + PAR + stop;
      f       = frame_bits(d, sel);
      waited  = 0;
      done_at = 0;
      wave_ok = 1'b1;
      dec     = '0;
      par_s   = 1'b0;
      t = 1'b1; bz = 1'b0; rd = 1'b0; dn = 1'b0;
      @(negedge clk);
      while (!(sel ? b_ready : a_ready) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " ready before accept"}, sel ? b_ready : a_ready, 1);
      if (sel) begin b_data = d; b_valid = 1'b1; end
      else     begin a_data = d; a_valid = 1'b1; end
      @(posedge clk);
      #1;
      if (sel) begin b_valid = 1'b0; b_data = ~d; end
      else     begin a_valid = 1'b0; a_data = ~d; end
      for (int k = 1; k <= nb * DIV + 5 && done_at == 0; k++) begin
         @(negedge clk);
         if (k == poke_at) begin
            if (sel) begin b_valid = 1'b1; b_data = 8'h00; end
            else     begin a_valid = 1'b1; a_data = 8'h00; end
         end else if (k == poke_at + 1) begin
            if (sel) b_valid = 1'b0; else a_valid = 1'b0;
         end
         t  = sel ? b_tx : a_tx;
         bz = sel ? b_busy : a_busy;
         rd = sel ? b_ready : a_ready;
         dn = sel ? b_done : a_done;
         if (dn) begin
            done_at = k;
         end else if (k <= nb * DIV) begin
            if (wave_ok && ({t, bz, rd} !== {f[(k-1)/DIV], 2'b10})) begin
               wave_ok = 1'b0;
               $display("FAIL %s waveform at cycle %0d: tx/busy/ready got %b%b%b expected %b10",
                        tag, k, t, bz, rd, f[(k-1)/DIV]);
            end
            if ((k - 1) % DIV == DIV / 2) begin
               if ((k - 1) / DIV >= 1 && (k - 1) / DIV <= 8) dec[(k-1)/DIV - 1] = t;
               if ((k - 1) / DIV == 9) par_s = t;
            end
         end
      end
      if (sel) b_valid = 1'b0; else a_valid = 1'b0;
      check({tag, " waveform"}, wave_ok, 1);
      check({tag, " tx_done cycle"}, done_at, exp_done);
      check({tag, " decoded byte"}, dec, d);
      check({tag, " tx/busy/ready at done"}, {t, bz, rd}, 3'b101);
`ifdef UART_TX_PARITY_EN
      check({tag, " parity bit"}, par_s, exp_par);
`else
      if (exp_par !== exp_par) $display("unreachable");
`endif
   endtask

   typedef struct {
      logic [7:0] data;
      bit         sel;
      int         exp_done;
      logic       exp_par;
   } vec_t;

   vec_t tbl[4];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int bad;
      int waited;
      int done_at;
      int lo_at;
      logic [7:0] d;
      bit sel;

      tbl[0] = '{8'h55, 1'b0, 101 + 10 * PAR, 1'b0};
      tbl[1] = '{8'hFF, 1'b1, 111 + 10 * PAR, 1'b1};
      tbl[2] = '{8'h07, 1'b0, 101 + 10 * PAR, 1'b1};
      tbl[3] = '{8'h07, 1'b1, 111 + 10 * PAR, 1'b0};

      // Reset values and tx_ready release timing
      @(negedge clk);
      check("reset A outputs {tx,ready,busy,done}", {a_tx, a_ready, a_busy, a_done}, 4'b1000);
      check("reset B outputs {tx,ready,busy,done}", {b_tx, b_ready, b_busy, b_done}, 4'b1000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready low right after release", a_ready, 0);
      @(negedge clk);
      check("ready after first edge", a_ready, 1);

      // Table-driven frames: 8N1/8N2, parity polarity
      for (int i = 0; i < 4; i++) begin
         send_check(tbl[i].data, tbl[i].sel, tbl[i].exp_done, 0, tbl[i].exp_par, $sformatf("tbl%0d", i));
      end

      // Back-to-back with tx_valid held high
      repeat (30) @(negedge clk);
      mon_q.delete();
      waited = 0;
      while (!a_ready && waited < 300) begin @(negedge clk); waited++; end
      a_data = 8'hA5;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_data = 8'h3C;
      done_at = 0;
      lo_at = 0;
      for (int k = 1; k <= 400 && lo_at == 0; k++) begin
         @(negedge clk);
         if (done_at != 0) begin
            a_valid = 1'b0;
            if (a_tx === 1'b0) lo_at = k;
         end
         if (a_done && done_at == 0) done_at = k;
      end
      a_valid = 1'b0;
      check("b2b first tx_done cycle", done_at, 101 + 10 * PAR);
      check("b2b second start offset", lo_at - done_at, 1);
      repeat (2 * (10 + PAR) * DIV) @(negedge clk);
      check("b2b frame count", mon_q.size(), 2);
      check("b2b frame 0", mon_q.size() > 0 ? mon_q[0] : 9'h1FF, 9'h0A5);
      check("b2b frame 1", mon_q.size() > 1 ? mon_q[1] : 9'h1FF, 9'h03C);

      // Reset during D3 of 0x00
      mon_q.delete();
      waited = 0;
      @(negedge clk);
      while (!a_ready && waited < 300) begin @(negedge clk); waited++; end
      a_data = 8'h00;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      repeat (45) @(negedge clk);
      check("rst-mid tx low in D3", a_tx, 0);
      #2;
      rst = 1'b1;
      #1;
      check("rst-mid async {tx,busy,done,ready}", {a_tx, a_busy, a_done, a_ready}, 4'b1000);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (a_done !== 1'b0 || a_tx !== 1'b1) bad++;
      end
      rst = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (a_done !== 1'b0 || a_tx !== 1'b1 || a_busy !== 1'b0) bad++;
      end
      check("rst-mid no tx_done/activity", bad, 0);
      check("rst-mid ready after release", a_ready, 1);
      send_check(8'hC3, 1'b0, 101 + 10 * PAR, 0, 1'b0, "post-reset");
      repeat (20) @(negedge clk);
      check("rst-mid monitor count", mon_q.size(), 1);
      check("rst-mid monitor byte", mon_q.size() > 0 ? mon_q[0] : 9'h1FF, 9'h0C3);

      // tx_valid pulsed mid-frame is ignored
      mon_q.delete();
      send_check(8'h81, 1'b0, 101 + 10 * PAR, 30, 1'b0, "poke");
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0) bad++;
      end
      check("poke no extra frame", bad, 0);
      check("poke monitor count", mon_q.size(), 1);
      check("poke monitor byte", mon_q.size() > 0 ? mon_q[0] : 9'h1FF, 9'h081);

      // Randomized frames against the reference frame model
      for (int r = 0; r < 8; r++) begin
         d = 8'($urandom_range(0, 255));
         sel = 1'($urandom_range(0, 1));
         send_check(d, sel, (9 + PAR + (sel ? 2 : 1)) * DIV + 1, 0, ^d ^ sel,
                    $sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
